// File: rtl/uart_aes_ctrl_if.sv
// Handshake bundle between the command sequencer and the UART/AES blocks around it.
// The master side is the sequencer; the slave side is the UART pair plus AES core.
interface uart_aes_ctrl_if;
  logic [7:0]   rx_dout;
  logic         rx_done_tick;
  logic [7:0]   tx_din;
  logic         tx_start;
  logic         tx_done_tick;
  logic [127:0] aes_key;
  logic [127:0] aes_in;
  logic         aes_start;
  logic [127:0] aes_out;
  logic         aes_done;
  logic         trigger;
  logic         busy;
  logic         key_valid;
  logic         error;

  modport master (
    input  rx_dout, rx_done_tick, tx_done_tick, aes_out, aes_done,
    output tx_din, tx_start, aes_key, aes_in, aes_start, trigger, busy, key_valid, error
  );

  modport slave (
    output rx_dout, rx_done_tick, tx_done_tick, aes_out, aes_done,
    input  tx_din, tx_start, aes_key, aes_in, aes_start, trigger, busy, key_valid, error
  );
endinterface

// File: rtl/uart_aes_ctrl.sv
// Command sequencer: assembles key/plaintext from UART bytes, launches one AES
// encryption under a scope trigger and streams the ciphertext (or an ack) back out.
module uart_aes_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter logic [7:0]  CMD_KEY        = 8'h4B,
  parameter logic [7:0]  CMD_PT         = 8'h50,
  parameter logic [7:0]  ACK_BYTE       = 8'h06
) (
  input logic             clk,
  input logic             reset,
  uart_aes_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIdle, StRxKey, StRxPt, StStart, StWaitAes, StTxLoad, StTxWait
  } state_e;

  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

  state_e       state_q;
  logic [3:0]   byte_cnt_q;
  logic [31:0]  idle_q;
  logic [127:0] data_q;
  logic [4:0]   tx_cnt_q;
  logic [7:0]   tx_din_q;
  logic         tx_start_q;
  logic [127:0] aes_key_q;
  logic [127:0] aes_in_q;
  logic         aes_start_q;
  logic         trigger_q;
  logic         key_valid_q;
  logic         error_q;
  logic [127:0] rx_word_d;

  assign rx_word_d = {data_q[119:0], bus.rx_dout};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      idle_q      <= '0;
      data_q      <= '0;
      tx_cnt_q    <= '0;
      tx_din_q    <= '0;
      tx_start_q  <= 1'b0;
      aes_key_q   <= '0;
      aes_in_q    <= '0;
      aes_start_q <= 1'b0;
      trigger_q   <= 1'b0;
      key_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      tx_start_q  <= 1'b0;
      aes_start_q <= 1'b0;
      error_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.rx_done_tick) begin
            if (bus.rx_dout == CMD_KEY) begin
              state_q    <= StRxKey;
              byte_cnt_q <= '0;
              idle_q     <= '0;
            end else if (bus.rx_dout == CMD_PT) begin
              if (key_valid_q) begin
                state_q    <= StRxPt;
                byte_cnt_q <= '0;
                idle_q     <= '0;
              end else begin
                error_q <= 1'b1;
              end
            end
          end
        end
        StRxKey, StRxPt: begin
          // A byte arriving on the terminal idle count wins over the timeout.
          if (bus.rx_done_tick) begin
            data_q     <= rx_word_d;
            idle_q     <= '0;
            byte_cnt_q <= byte_cnt_q + 4'd1;
            if (byte_cnt_q == 4'd15) begin
              if (state_q == StRxKey) begin
                key_valid_q <= 1'b1;
                aes_key_q   <= rx_word_d;
                data_q      <= {ACK_BYTE, 120'd0};
                tx_cnt_q    <= 5'd1;
                state_q     <= StTxLoad;
              end else begin
                aes_in_q    <= rx_word_d;
                aes_start_q <= 1'b1;
                trigger_q   <= 1'b1;
                state_q     <= StStart;
              end
            end
          end else if (idle_q == TimeoutLast) begin
            error_q <= 1'b1;
            state_q <= StIdle;
          end else begin
            idle_q <= idle_q + 32'd1;
          end
        end
        StStart: state_q <= StWaitAes;
        StWaitAes: begin
          if (bus.aes_done) begin
            data_q    <= bus.aes_out;
            tx_cnt_q  <= 5'd16;
            trigger_q <= 1'b0;
            state_q   <= StTxLoad;
          end
        end
        StTxLoad: begin
          tx_din_q   <= data_q[127:120];
          tx_start_q <= 1'b1;
          state_q    <= StTxWait;
        end
        StTxWait: begin
          if (bus.tx_done_tick) begin
            data_q   <= {data_q[119:0], 8'h00};
            tx_cnt_q <= tx_cnt_q - 5'd1;
            state_q  <= (tx_cnt_q == 5'd1) ? StIdle : StTxLoad;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.tx_din    = tx_din_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.aes_key   = aes_key_q;
  assign bus.aes_in    = aes_in_q;
  assign bus.aes_start = aes_start_q;
  assign bus.trigger   = trigger_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.key_valid = key_valid_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_uart_aes_ctrl.sv
// Directed bench for uart_aes_ctrl: vector table of command transactions plus
// hand-timed sequences for key load, encryption, timeout and mid-transmit reset.
module tb_uart_aes_ctrl;
  localparam int unsigned TO = 100;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ACK_TX = {8'h06, 120'd0};

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_aes_ctrl_if bus ();

  uart_aes_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .CMD_KEY       (8'h4B),
    .CMD_PT        (8'h50),
    .ACK_BYTE      (8'h06)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // UART transmitter and AES core models
  int          cyc_n = 0;
  bit          tx_busy = 0;
  int          tx_timer = 0;
  logic [7:0]  tx_hold;
  logic [7:0]  tx_log[$];
  int          start_cyc[$];
  int          done_cyc[$];
  bit          aes_pend = 0;
  int          aes_timer = 0;
  int          n_aes_start = 0;
  int          trig_cyc = 0;
  int          err_cyc = 0;
  logic        prev_err = 1'b0;

  initial begin
    bus.tx_done_tick = 1'b0;
    bus.aes_done = 1'b0;
    bus.aes_out = ~CT;
    forever begin
      @(negedge clk);
      cyc_n++;
      bus.tx_done_tick = 1'b0;
      bus.aes_done = 1'b0;
      bus.aes_out = ~CT;
      if (!reset) begin
        tx_busy = 0;
        aes_pend = 0;
        prev_err = 1'b0;
      end else begin
        if (bus.trigger) trig_cyc++;
        if (bus.error) begin
          err_cyc++;
          check("error_one_cycle", prev_err, 1'b0);
        end
        prev_err = bus.error;
        if (bus.aes_start) begin
          n_aes_start++;
          aes_pend = 1;
          aes_timer = 9;
        end else if (aes_pend) begin
          aes_timer--;
          if (aes_timer == 0) begin
            aes_pend = 0;
            bus.aes_done = 1'b1;
            bus.aes_out = CT;
          end
        end
        if (bus.tx_start) begin
          check("tx_start_while_busy", tx_busy, 1'b0);
          tx_log.push_back(bus.tx_din);
          start_cyc.push_back(cyc_n);
          tx_hold = bus.tx_din;
          tx_busy = 1;
          tx_timer = 3;
        end else if (tx_busy) begin
          check("tx_din_stable", bus.tx_din, tx_hold);
          tx_timer--;
          if (tx_timer == 0) begin
            tx_busy = 0;
            bus.tx_done_tick = 1'b1;
            done_cyc.push_back(cyc_n);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    bus.rx_dout = b;
    bus.rx_done_tick = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    put(b);
    repeat (gap) cyc();
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (!bus.busy && !tx_busy) break;
      cyc();
    end
    check({name, "_busy"}, bus.busy, 1'b0);
    check({name, "_txbusy"}, tx_busy, 1'b0);
    repeat (3) cyc();
  endtask

  task automatic check_zero(input string name);
    check({name, "_key"}, bus.aes_key, '0);
    check({name, "_in"}, bus.aes_in, '0);
    check({name, "_ctl"}, {bus.tx_din, bus.tx_start, bus.aes_start, bus.trigger, bus.busy,
                           bus.key_valid, bus.error}, '0);
  endtask

  task automatic clear_logs();
    tx_log.delete();
    start_cyc.delete();
    done_cyc.delete();
    err_cyc = 0;
    trig_cyc = 0;
    n_aes_start = 0;
  endtask

  function automatic logic [127:0] tx_word();
    logic [127:0] w = '0;
    for (int j = 0; j < tx_log.size() && j < 16; j++) w[127 - 8*j -: 8] = tx_log[j];
    return w;
  endfunction

  typedef struct {
    logic [7:0]   cmd;
    logic [127:0] pay;
    int           npay;
    int           exp_err;
    int           exp_starts;
    int           exp_ntx;
    logic [127:0] exp_tx;
    logic         exp_kv;
    logic [127:0] exp_key;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int first_k;
    int n_tx;
    vecs[0] = '{8'h50, PT, 16, 1, 0, 0,  '0,     1'b0, '0};  // plaintext without key
    vecs[1] = '{8'h41, '0, 0,  0, 0, 0,  '0,     1'b0, '0};  // unknown byte ignored
    vecs[2] = '{8'h4B, K1, 16, 0, 0, 1,  ACK_TX, 1'b1, K1};  // key load + ack
    vecs[3] = '{8'h50, PT, 16, 0, 1, 16, CT,     1'b1, K1};  // encryption
    vecs[4] = '{8'h4B, K2, 16, 0, 0, 1,  ACK_TX, 1'b1, K2};  // key reload

    bus.rx_dout = '0;
    bus.rx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    repeat (2) cyc();

    for (int v = 0; v < 5; v++) begin
      clear_logs();
      send(vecs[v].cmd, 2);
      for (int i = 0; i < vecs[v].npay; i++) send(vecs[v].pay[127 - 8*i -: 8], 2);
      wait_idle($sformatf("v%0d", v));
      check($sformatf("v%0d_err", v), err_cyc, vecs[v].exp_err);
      check($sformatf("v%0d_starts", v), n_aes_start, vecs[v].exp_starts);
      check($sformatf("v%0d_ntx", v), tx_log.size(), vecs[v].exp_ntx);
      check($sformatf("v%0d_tx", v), tx_word(), vecs[v].exp_tx);
      check($sformatf("v%0d_kv", v), bus.key_valid, vecs[v].exp_kv);
      check($sformatf("v%0d_key", v), bus.aes_key, vecs[v].exp_key);
    end

    // Key load timing from a fresh reset
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_logs();
    send(8'h4B, 2);
    for (int i = 0; i < 15; i++) send(K1[127 - 8*i -: 8], 2);
    put(K1[7:0]);
    check("key_n_kv", bus.key_valid, 1'b0);
    check("key_n_key", bus.aes_key, '0);
    cyc();
    check("key_n1_kv", bus.key_valid, 1'b1);
    check("key_n1_key", bus.aes_key, K1);
    check("key_n1_txstart", bus.tx_start, 1'b0);
    cyc();
    check("key_n2_txstart", bus.tx_start, 1'b1);
    check("key_n2_txdin", bus.tx_din, 8'h06);
    wait_idle("key");
    check("key_ntx", tx_log.size(), 1);

    // Encryption timing with rx bytes injected in WAIT_AES and TX_WAIT
    clear_logs();
    send(8'h50, 2);
    for (int i = 0; i < 15; i++) send(PT[127 - 8*i -: 8], 2);
    put(PT[7:0]);
    for (int c = 1; c <= 14; c++) begin
      cyc();
      if (c == 1) begin
        check("enc_c1_start", bus.aes_start, 1'b1);
        check("enc_c1_trig", bus.trigger, 1'b1);
        check("enc_c1_in", bus.aes_in, PT);
      end
      if (c == 2) begin
        check("enc_c2_start", bus.aes_start, 1'b0);
        check("enc_c2_trig", bus.trigger, 1'b1);
      end
      if (c == 5 || c == 14) begin
        bus.rx_dout = (c == 5) ? 8'h4B : 8'h50;
        bus.rx_done_tick = 1'b1;
      end
      if (c == 10) check("enc_c10_trig", bus.trigger, 1'b1);
      if (c == 11) begin
        check("enc_c11_trig", bus.trigger, 1'b0);
        check("enc_c11_txstart", bus.tx_start, 1'b0);
      end
      if (c == 12) begin
        check("enc_c12_txstart", bus.tx_start, 1'b1);
        check("enc_c12_txdin", bus.tx_din, 8'h69);
      end
    end
    wait_idle("enc");
    check("enc_starts", n_aes_start, 1);
    check("enc_trig_width", trig_cyc, 10);
    check("enc_err", err_cyc, 0);
    check("enc_ntx", tx_log.size(), 16);
    check("enc_tx", tx_word(), CT);
    check("enc_key", bus.aes_key, K1);
    check("enc_ndone", done_cyc.size(), 16);
    for (int i = 1; i < start_cyc.size() && i < done_cyc.size(); i++)
      check($sformatf("enc_gap%0d", i), start_cyc[i] - done_cyc[i-1], 2);

    // Timeout: byte on the terminal count wins, then a genuine timeout
    clear_logs();
    put(8'h4B);
    repeat (99) cyc();
    put(8'hAA);
    cyc();
    check("to_tie_err", err_cyc + int'(bus.error), 0);
    check("to_tie_busy", bus.busy, 1'b1);
    for (int i = 0; i < 3; i++) send(8'h10 + 8'(i), 2);
    put(8'h13);
    first_k = -1;
    for (int k = 1; k <= 200; k++) begin
      cyc();
      if (bus.error) begin
        first_k = k;
        break;
      end
    end
    check("to_latency", first_k, 101);
    cyc();
    check("to_err_drop", bus.error, 1'b0);
    check("to_busy", bus.busy, 1'b0);
    check("to_err_cnt", err_cyc, 1);
    check("to_key", bus.aes_key, K1);
    check("to_kv", bus.key_valid, 1'b1);

    // Reset in the middle of the ciphertext transmit
    clear_logs();
    send(8'h50, 2);
    for (int i = 0; i < 16; i++) send(PT[127 - 8*i -: 8], 2);
    for (int i = 0; i < 500 && tx_log.size() < 3; i++) cyc();
    check("rst_mid_ntx", tx_log.size() >= 3, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero("rst_mid");
    repeat (2) cyc();
    reset = 1'b1;
    n_tx = tx_log.size();
    repeat (40) cyc();
    check("rst_after_ntx", tx_log.size(), n_tx);
    check_zero("rst_after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
